// File: rtl/sp_pkg.sv
// Shared types and sizing helpers for the signal-probability window estimator.
package sp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DIV,
        OUT
    } sp_state_e;

    localparam int unsigned SP_CH   = 32;
    localparam int unsigned SP_CW   = 21;
    localparam int unsigned SP_FRAC = 16;

    localparam int unsigned SP_CH_W  = $clog2(SP_CH);
    localparam int unsigned SP_RES_W = SP_FRAC + 1;

    function automatic int unsigned ch_width(input int unsigned ch);
        return (ch < 2) ? 1 : $clog2(ch);
    endfunction

    function automatic int unsigned res_width(input int unsigned frac);
        return frac + 1;
    endfunction

endpackage

// File: rtl/sp_frac_div.sv
// Iterative restoring divider producing floor(num*2^FRAC/den) as UQ1.FRAC, num <= den.
module sp_frac_div #(
    parameter int unsigned CW   = 21,
    parameter int unsigned FRAC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [CW-1:0] num,
    input  logic [CW-1:0] den,
    output logic          busy,
    output logic [FRAC:0] q,
    output logic          q_valid
);
    localparam int unsigned RW = FRAC + 1;
    localparam int unsigned SW = $clog2(FRAC + 1) + 1;

    logic [CW:0]   rem, rem_nxt, rem_sh;
    logic [FRAC:0] q_reg, q_nxt;
    logic [SW-1:0] step, step_nxt;
    logic          active, active_nxt;

    // q and q_valid reflect the step completing this cycle, so the caller can
    // capture the finished quotient on the same edge as the final step.
    always_comb begin
        rem_nxt    = rem;
        q_nxt      = q_reg;
        step_nxt   = step;
        active_nxt = active;
        rem_sh     = {rem[CW-1:0], 1'b0};
        if (active) begin
            if (rem_sh >= {1'b0, den}) begin
                rem_nxt = rem_sh - {1'b0, den};
                q_nxt   = q_reg | (RW'(1) << (SW'(FRAC) - step));
            end else begin
                rem_nxt = rem_sh;
            end
            step_nxt = step + SW'(1);
            if (step == SW'(FRAC)) begin
                active_nxt = 1'b0;
            end
        end else if (go) begin
            if (num == den) begin
                rem_nxt = '0;
                q_nxt   = {1'b1, {FRAC{1'b0}}};
            end else begin
                rem_nxt = {1'b0, num};
                q_nxt   = '0;
            end
            step_nxt   = SW'(1);
            active_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            q_reg  <= '0;
            step   <= '0;
            active <= 1'b0;
        end else begin
            rem    <= rem_nxt;
            q_reg  <= q_nxt;
            step   <= step_nxt;
            active <= active_nxt;
        end
    end

    assign busy    = active;
    assign q       = q_nxt;
    assign q_valid = active && (step == SW'(FRAC));

endmodule

// File: rtl/sp_window_estimator.sv
// Per-bit signal-probability estimator over a programmable window of sampled cycles.
// Optional toggle-rate output is enabled by defining SP_TOGGLE_EN.
module sp_window_estimator
    import sp_pkg::*;
#(
    parameter int unsigned CH   = SP_CH,
    parameter int unsigned CW   = SP_CW,
    parameter int unsigned FRAC = SP_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         win_len,
    input  logic                  en,
    input  logic [CH-1:0]         word,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [$clog2(CH)-1:0] res_ch,
    output logic [FRAC:0]         res_sp,
`ifdef SP_TOGGLE_EN
    output logic [FRAC:0]         res_tog,
`endif
    output logic                  done
);
    localparam int unsigned CHW = ch_width(CH);
    localparam int unsigned RW  = res_width(FRAC);
    localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

    sp_state_e       state, state_nxt;
    logic [CW-1:0]   win_q, smp_cnt;
    logic [CW-1:0]   hi_cnt [CH];
    logic [CHW-1:0]  ch;
    logic            start_ok, sample, win_close, handshake;
    logic            div_go, div_busy, div_q_valid, div_last, sp_load;
    logic [CW-1:0]   div_num;
    logic [RW-1:0]   div_q;

    assign start_ok  = (state == IDLE) && start && (win_len != '0);
    assign sample    = (state == COUNT) && en;
    assign win_close = sample && (CW'(smp_cnt + CW'(1)) == win_q);
    assign handshake = (state == OUT) && res_ready;
    assign div_go    = (state == DIV) && !div_busy;
    assign res_ch    = ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) state_nxt = COUNT;
            end
            COUNT: if (win_close) state_nxt = DIV;
            DIV:   if (div_last) state_nxt = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = (ch == LAST_CH) ? IDLE : DIV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            smp_cnt <= '0;
            ch      <= '0;
            res_sp  <= '0;
            done    <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) hi_cnt[i] <= '0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                win_q   <= win_len;
                smp_cnt <= '0;
                for (int unsigned i = 0; i < CH; i++) hi_cnt[i] <= '0;
            end
            if (sample) begin
                smp_cnt <= smp_cnt + CW'(1);
                for (int unsigned i = 0; i < CH; i++) hi_cnt[i] <= hi_cnt[i] + CW'(word[i]);
                if (win_close) ch <= '0;
            end
            if (sp_load) res_sp <= div_q;
            if (handshake) begin
                if (ch == LAST_CH) done <= 1'b1;
                else               ch   <= ch + CHW'(1);
            end
        end
    end

`ifdef SP_TOGGLE_EN
    logic [CW-1:0] tog_cnt [CH];
    logic [CH-1:0] prev_word;
    logic          pass;

    // Each channel is divided twice: pass 0 for hi_cnt, pass 1 for tog_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word <= '0;
            pass      <= 1'b0;
            res_tog   <= '0;
            for (int unsigned i = 0; i < CH; i++) tog_cnt[i] <= '0;
        end else begin
            if (start_ok) begin
                for (int unsigned i = 0; i < CH; i++) tog_cnt[i] <= '0;
            end
            if (sample) begin
                prev_word <= word;
                if (smp_cnt != '0) begin
                    for (int unsigned i = 0; i < CH; i++)
                        tog_cnt[i] <= tog_cnt[i] + CW'(word[i] ^ prev_word[i]);
                end
            end
            if (div_q_valid) begin
                pass <= !pass;
                if (pass) res_tog <= div_q;
            end
        end
    end

    assign div_num  = pass ? tog_cnt[ch] : hi_cnt[ch];
    assign div_last = div_q_valid && pass;
    assign sp_load  = div_q_valid && !pass;
`else
    assign div_num  = hi_cnt[ch];
    assign div_last = div_q_valid;
    assign sp_load  = div_q_valid;
`endif

    sp_frac_div #(
        .CW   (CW),
        .FRAC (FRAC)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (div_go),
        .num     (div_num),
        .den     (win_q),
        .busy    (div_busy),
        .q       (div_q),
        .q_valid (div_q_valid)
    );

endmodule
